// File: rtl/dec_bcd_pkg.sv
// Shared definitions for the decimal-key to BCD encoder.
//   DEC_W / BCD_W    : width of the decimal key bank and of one BCD digit
//   state_t          : key-scan FSM states
//   onehot10_to_bcd  : returns {is_onehot, bcd[3:0]} for a 10-line key vector
package dec_bcd_pkg;

  localparam int DEC_W = 10;
  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // The index is only meaningful when exactly one line is set; for a
  // multi-hot vector it holds the highest set line and is ignored upstream.
  function automatic logic [BCD_W:0] onehot10_to_bcd(input logic [DEC_W-1:0] d);
    logic [BCD_W-1:0] idx;
    logic [3:0]       ones;
    idx  = '0;
    ones = '0;
    for (int i = 0; i < DEC_W; i++) begin
      if (d[i]) begin
        idx  = BCD_W'(i);
        ones = ones + 4'd1;
      end
    end
    return {(ones == 4'd1), idx};
  endfunction

endpackage

// File: rtl/dec10_onehot_enc.sv
// Combinational one-hot check and index encoder for a 10-line key vector.
//   d         in  10  debounced key sample
//   is_onehot out 1   exactly one line of d is set
//   bcd       out 4   index of the set line (valid when is_onehot)
module dec10_onehot_enc
  import dec_bcd_pkg::*;
(
  input  logic [DEC_W-1:0] d,
  output logic             is_onehot,
  output logic [BCD_W-1:0] bcd
);

  logic [BCD_W:0] enc;

  assign enc       = onehot10_to_bcd(d);
  assign is_onehot = enc[BCD_W];
  assign bcd       = enc[BCD_W-1:0];

endmodule

// File: rtl/dec_to_bcd_key_encoder.sv
// Decimal key bank to BCD encoder with debounce, multi-key rejection and a
// shift register of accepted digits.
//   clk    in   1            rising-edge clock
//   rst    in   1            synchronous active-high reset
//   D      in   10           key lines, D[k]=1 means key k pressed
//   EN_N   in   1            active-low enable; high forces IDLE, no strobes
//   CLR    in   1            synchronous clear of DIGITS and COUNT
//   BCD    out  4            last accepted digit
//   VALID  out  1            one-cycle strobe: digit accepted and shifted in
//   ERR    out  1            one-cycle strobe: debounced press was multi-hot
//   DIGITS out  4*NUM_DIGITS accepted digits, newest in [3:0]
//   COUNT  out  clog2(N+1)   digits held, saturating at NUM_DIGITS
module dec_to_bcd_key_encoder
  import dec_bcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_DIGITS      = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DEC_W-1:0]                 D,
  input  logic                             EN_N,
  input  logic                             CLR,
  output logic [BCD_W-1:0]                 BCD,
  output logic                             VALID,
  output logic                             ERR,
  output logic [BCD_W*NUM_DIGITS-1:0]      DIGITS,
  output logic [$clog2(NUM_DIGITS+1)-1:0]  COUNT
);

  localparam int DIG_W   = BCD_W * NUM_DIGITS;
  localparam int COUNT_W = $clog2(NUM_DIGITS + 1);
  localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // The counter runs 0..DEBOUNCE_CYCLES-1; the last value marks the final
  // required matching sample.
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(NUM_DIGITS);

  state_t             state_reg,  state_next;
  logic [CNT_W-1:0]   cnt_reg,    cnt_next;
  logic [DEC_W-1:0]   sample_reg, sample_next;
  logic [BCD_W-1:0]   bcd_reg,    bcd_next;
  logic               valid_reg,  valid_next;
  logic               err_reg,    err_next;
  logic [DIG_W-1:0]   digits_reg, digits_next;
  logic [COUNT_W-1:0] count_reg,  count_next;

  logic               enc_onehot;
  logic [BCD_W-1:0]   enc_bcd;
  logic               shift_in;
  logic [DIG_W-1:0]   digits_base;
  logic [COUNT_W-1:0] count_base;
  logic [DIG_W-1:0]   digits_shifted;

  dec10_onehot_enc u_enc (
    .d         (sample_reg),
    .is_onehot (enc_onehot),
    .bcd       (enc_bcd)
  );

  // Clear is applied before a coincident shift, so the new digit lands in
  // an empty register.
  assign digits_base = CLR ? '0 : digits_reg;
  assign count_base  = CLR ? '0 : count_reg;

  generate
    if (NUM_DIGITS == 1) begin : g_shift_one
      assign digits_shifted = enc_bcd;
    end else begin : g_shift_many
      assign digits_shifted = {digits_base[DIG_W-BCD_W-1:0], enc_bcd};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      sample_reg <= '0;
      bcd_reg    <= '0;
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
      digits_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      sample_reg <= sample_next;
      bcd_reg    <= bcd_next;
      valid_reg  <= valid_next;
      err_reg    <= err_next;
      digits_reg <= digits_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    sample_next = sample_reg;
    bcd_next    = bcd_reg;
    valid_next  = 1'b0;
    err_next    = 1'b0;
    shift_in    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (D != '0) begin
          sample_next = D;
          cnt_next    = '0;
          state_next  = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (D != sample_reg) begin
          // Bounce: drop the press silently.
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HOLD;
          if (enc_onehot) begin
            bcd_next   = enc_bcd;
            valid_next = 1'b1;
            shift_in   = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        if (D == '0) begin
          cnt_next   = '0;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (D != '0) begin
          state_next = HOLD;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Disable wins over everything the FSM decided this cycle.
    if (EN_N) begin
      state_next = IDLE;
      bcd_next   = bcd_reg;
      valid_next = 1'b0;
      err_next   = 1'b0;
      shift_in   = 1'b0;
    end

    if (shift_in) begin
      digits_next = digits_shifted;
      count_next  = (count_base == COUNT_MAX) ? COUNT_MAX : count_base + 1'b1;
    end else begin
      digits_next = digits_base;
      count_next  = count_base;
    end
  end

  assign BCD    = bcd_reg;
  assign VALID  = valid_reg;
  assign ERR    = err_reg;
  assign DIGITS = digits_reg;
  assign COUNT  = count_reg;

endmodule
